// File: rtl/key_event_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_arbiter_if
// Description : Source-side and consumer-side handshake bundle for the
//               multi-channel key event arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_arbiter_if #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 3,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 8
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    logic [CHANNELS-1:0]            src_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] src_data;
    logic [CHANNELS-1:0]            src_read_fin;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [CW-1:0]                  out_chan;
    logic                           out_read_fin;
    logic [FW-1:0]                  fifo_count;
    logic [CNT_WIDTH-1:0]           drop_count;

    // Master drives the sources and the consumer ack; slave is the arbiter.
    modport master (
        output src_ready, src_data, out_read_fin,
        input  src_read_fin, out_ready, out_data, out_chan, fifo_count, drop_count
    );

    modport slave (
        input  src_ready, src_data, out_read_fin,
        output src_read_fin, out_ready, out_data, out_chan, fifo_count, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/key_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : key_event_arbiter
// Description : Round-robin capture of N ready/read_fin event sources into a
//               first-word-fall-through FIFO tagged with the source channel.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_arbiter #(
    parameter int CHANNELS       = 2,
    parameter int DATA_WIDTH     = 3,
    parameter int DEPTH          = 8,
    parameter int DROP_WHEN_FULL = 0,
    parameter int CNT_WIDTH      = 8
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    key_event_arbiter_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = CW + DATA_WIDTH;

    logic [EW-1:0]        r_mem [DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [FW-1:0]        r_count;
    logic [CW-1:0]        r_rr;
    logic [CHANNELS-1:0]  r_armed;
    logic [CHANNELS-1:0]  r_fin;
    logic                 r_rfin_q;
    logic [CNT_WIDTH-1:0] r_drop;

    logic [CHANNELS-1:0]  w_elig;
    logic                 w_found;
    logic [CW-1:0]        w_gnt;
    logic [CW-1:0]        w_rr_next;
    logic [CHANNELS-1:0]  w_onehot;
    logic [EW-1:0]        w_head;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_room;
    logic                 w_grant;
    logic                 w_push;
    logic                 w_drop;
    int unsigned          w_sum;

    assign w_elig = bus.src_ready & r_armed;

    // First eligible channel at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_sum = int'(r_rr) + k;
            if (w_sum >= CHANNELS) begin
                w_sum = w_sum - CHANNELS;
            end
            if (!w_found && w_elig[CW'(w_sum)]) begin
                w_found = 1'b1;
                w_gnt   = CW'(w_sum);
            end
        end
    end

    assign w_pop     = bus.out_read_fin & ~r_rfin_q & (r_count != '0);
    assign w_full    = (r_count == FW'(DEPTH));
    assign w_room    = !w_full || w_pop;
    assign w_grant   = w_found && (w_room || (DROP_WHEN_FULL != 0));
    assign w_push    = w_found && w_room;
    assign w_drop    = w_found && !w_room && (DROP_WHEN_FULL != 0);
    assign w_rr_next = (w_gnt == CW'(CHANNELS - 1)) ? '0 : w_gnt + CW'(1);
    assign w_onehot  = w_grant ? (CHANNELS'(1) << w_gnt) : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rr     <= '0;
            r_armed  <= '1;
            r_fin    <= '0;
            r_rfin_q <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_rfin_q <= bus.out_read_fin;
            r_fin    <= w_onehot;
            if (w_grant) begin
                r_rr <= w_rr_next;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_onehot[i]) begin
                    r_armed[i] <= 1'b0;
                end else if (!bus.src_ready[i]) begin
                    r_armed[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FW'(1);
                2'b01:   r_count <= r_count - FW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + CNT_WIDTH'(1);
            end
        end
    end

    // Storage carries no reset; the head is masked to zero whenever empty.
    always_ff @(posedge clock) begin
        if (reset_n && w_push) begin
            r_mem[r_wptr] <= {w_gnt, bus.src_data[w_gnt*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    assign w_head           = r_mem[r_rptr];
    assign bus.out_ready    = (r_count != '0);
    assign bus.out_data     = bus.out_ready ? w_head[DATA_WIDTH-1:0] : '0;
    assign bus.out_chan     = bus.out_ready ? w_head[EW-1:DATA_WIDTH] : '0;
    assign bus.fifo_count   = r_count;
    assign bus.drop_count   = r_drop;
    assign bus.src_read_fin = r_fin;
endmodule
`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_arbiter
// Description : Scoreboard bench for key_event_arbiter, back-pressure and
//               drop-when-full instances side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_arbiter;
    localparam int CH  = 2;
    localparam int DW  = 3;
    localparam int DEP = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    key_event_arbiter_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEP), .CNT_WIDTH(8)) bus_a ();
    key_event_arbiter_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEP), .CNT_WIDTH(2)) bus_b ();

    key_event_arbiter #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEP),
                        .DROP_WHEN_FULL(0), .CNT_WIDTH(8)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a.slave));

    key_event_arbiter #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEP),
                        .DROP_WHEN_FULL(1), .CNT_WIDTH(2)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

    int n_run  = 0;
    int n_fail = 0;
    int q_a[$];
    int q_b[$];
    int rr_a   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int get_fin(input bit b);
        return b ? int'(bus_b.src_read_fin) : int'(bus_a.src_read_fin);
    endfunction
    function automatic int get_rdy(input bit b);
        return b ? int'(bus_b.out_ready) : int'(bus_a.out_ready);
    endfunction
    function automatic int get_cnt(input bit b);
        return b ? int'(bus_b.fifo_count) : int'(bus_a.fifo_count);
    endfunction
    function automatic int get_drop(input bit b);
        return b ? int'(bus_b.drop_count) : int'(bus_a.drop_count);
    endfunction
    // Head packed as chan*8 + data, matching the scoreboard entries.
    function automatic int get_head(input bit b);
        return b ? int'({bus_b.out_chan, bus_b.out_data}) : int'({bus_a.out_chan, bus_a.out_data});
    endfunction

    task automatic set_src(input bit b, input int ch, input bit rdy, input int d);
        if (b) begin
            bus_b.src_ready[ch]        = rdy;
            bus_b.src_data[ch*DW +: DW] = DW'(d);
        end else begin
            bus_a.src_ready[ch]        = rdy;
            bus_a.src_data[ch*DW +: DW] = DW'(d);
        end
    endtask

    task automatic set_rfin(input bit b, input bit v);
        if (b) bus_b.out_read_fin = v;
        else   bus_a.out_read_fin = v;
    endtask

    task automatic send(input bit b, input int ch, input int d, input bit push);
        int seen;
        seen = 0;
        if (push) begin
            if (b) q_b.push_back(ch*8 + d);
            else   q_a.push_back(ch*8 + d);
        end
        set_src(b, ch, 1'b1, d);
        for (int k = 0; k < 20 && seen == 0; k++) begin
            tick();
            seen = (get_fin(b) >> ch) & 1;
        end
        check_eq($sformatf("ack_%0d_ch%0d", b, ch), seen, 1);
        if (!b && seen != 0) rr_a = (ch + 1) % CH;
        set_src(b, ch, 1'b0, d);
        tick();
    endtask

    task automatic both(input int d0, input int d1);
        int seen;
        int first;
        seen  = 0;
        first = rr_a;
        q_a.push_back(first*8 + (first == 0 ? d0 : d1));
        q_a.push_back((1-first)*8 + (first == 0 ? d1 : d0));
        set_src(1'b0, 0, 1'b1, d0);
        set_src(1'b0, 1, 1'b1, d1);
        for (int k = 0; k < 10 && seen != 3; k++) begin
            tick();
            seen = seen | get_fin(1'b0);
        end
        check_eq("both_acks", seen, 3);
        set_src(1'b0, 0, 1'b0, d0);
        set_src(1'b0, 1, 1'b0, d1);
        tick();
    endtask

    task automatic pop_check(input bit b);
        int exp;
        exp = -1;
        check_eq($sformatf("pop_ready_%0d", b), get_rdy(b), 1);
        if (b && q_b.size() > 0)       exp = q_b.pop_front();
        else if (!b && q_a.size() > 0) exp = q_a.pop_front();
        check_eq($sformatf("head_%0d", b), get_head(b), exp);
        set_rfin(b, 1'b1);
        tick();
        set_rfin(b, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        int first;
        int f;
        int acc;
        int exp;
        bus_a.src_ready = '0; bus_a.src_data = '0; bus_a.out_read_fin = 1'b0;
        bus_b.src_ready = '0; bus_b.src_data = '0; bus_b.out_read_fin = 1'b0;
        tick(); tick();
        check_eq("rst_ready", get_rdy(0), 0);
        check_eq("rst_count", get_cnt(0), 0);
        check_eq("rst_fin", get_fin(0), 0);
        check_eq("rst_head", get_head(0), 0);
        check_eq("rst_drop_a", get_drop(0), 0);
        check_eq("rst_drop_b", get_drop(1), 0);
        reset_n = 1'b1;
        tick();

        // Single event, exact latency, single-cycle ack, then pop.
        set_src(0, 0, 1'b1, 5);
        tick();
        check_eq("t1_fin", get_fin(0), 1);
        check_eq("t1_ready", get_rdy(0), 1);
        check_eq("t1_head", get_head(0), 5);
        check_eq("t1_count", get_cnt(0), 1);
        set_src(0, 0, 1'b0, 5);
        rr_a = 1;
        tick();
        check_eq("t1_fin_pulse", get_fin(0), 0);
        set_rfin(0, 1'b1);
        tick();
        check_eq("t1_pop_ready", get_rdy(0), 0);
        check_eq("t1_pop_count", get_cnt(0), 0);
        tick();
        check_eq("t1_hold_count", get_cnt(0), 0);
        set_rfin(0, 1'b0);
        tick();

        // Both held ready: one ack each, order from the round-robin pointer.
        c0 = 0; c1 = 0; first = -1;
        q_a.push_back(rr_a*8 + (rr_a == 0 ? 2 : 6));
        q_a.push_back((1-rr_a)*8 + (rr_a == 0 ? 6 : 2));
        set_src(0, 0, 1'b1, 2);
        set_src(0, 1, 1'b1, 6);
        for (int k = 0; k < 8; k++) begin
            tick();
            f = get_fin(0);
            if (f[0]) begin c0++; if (first < 0) first = 0; end
            if (f[1]) begin c1++; if (first < 0) first = 1; end
        end
        check_eq("t2_acks_ch0", c0, 1);
        check_eq("t2_acks_ch1", c1, 1);
        check_eq("t2_first", first, rr_a);
        check_eq("t2_count", get_cnt(0), 2);
        set_src(0, 0, 1'b0, 2);
        set_src(0, 1, 1'b0, 6);
        tick();
        pop_check(0);
        pop_check(0);

        // Round-robin fairness across rounds that shift the pointer.
        both(1, 2);
        send(0, 1, 3, 1'b1);
        both(4, 5);
        send(0, 0, 6, 1'b1);
        both(7, 0);
        check_eq("t3_count", get_cnt(0), 8);
        for (int k = 0; k < 8; k++) pop_check(0);
        check_eq("t3_empty", get_cnt(0), 0);

        // Back-pressure when full, then simultaneous pop and capture.
        for (int k = 0; k < 8; k++) send(0, 0, k, 1'b1);
        check_eq("t4_full", get_cnt(0), 8);
        q_a.push_back(8 + 7);
        set_src(0, 1, 1'b1, 7);
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            acc = acc | get_fin(0);
        end
        check_eq("t4_blocked_fin", acc, 0);
        check_eq("t4_blocked_count", get_cnt(0), 8);
        exp = q_a.pop_front();
        check_eq("t4_head", get_head(0), exp);
        set_rfin(0, 1'b1);
        tick();
        check_eq("t4_late_ack", get_fin(0), 2);
        check_eq("t4_count_hold", get_cnt(0), 8);
        rr_a = 0;
        set_src(0, 1, 1'b0, 7);
        set_rfin(0, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) pop_check(0);
        check_eq("t4_empty", get_cnt(0), 0);

        // Drop-when-full instance with a saturating 2-bit counter.
        for (int k = 0; k < 8; k++) send(1, k % 2, 7 - k, 1'b1);
        check_eq("t5_full", get_cnt(1), 8);
        check_eq("t5_drop0", get_drop(1), 0);
        send(1, 1, 3, 1'b0);
        send(1, 0, 6, 1'b0);
        check_eq("t5_drop2", get_drop(1), 2);
        send(1, 1, 1, 1'b0);
        check_eq("t5_drop3", get_drop(1), 3);
        send(1, 0, 2, 1'b0);
        send(1, 1, 4, 1'b0);
        check_eq("t5_drop_sat", get_drop(1), 3);
        check_eq("t5_count", get_cnt(1), 8);
        for (int k = 0; k < 8; k++) pop_check(1);
        check_eq("t5_empty", get_cnt(1), 0);

        // Mid-operation reset with a pending capture and ack held high.
        for (int k = 0; k < 5; k++) send(0, k % 2, k + 1, 1'b1);
        check_eq("t6_count5", get_cnt(0), 5);
        set_src(0, 0, 1'b1, 4);
        set_rfin(0, 1'b1);
        reset_n = 1'b0;
        tick();
        check_eq("t6_rst_ready", get_rdy(0), 0);
        check_eq("t6_rst_count", get_cnt(0), 0);
        check_eq("t6_rst_fin", get_fin(0), 0);
        check_eq("t6_rst_head", get_head(0), 0);
        check_eq("t6_rst_drop_b", get_drop(1), 0);
        reset_n = 1'b1;
        set_src(0, 0, 1'b0, 4);
        tick();
        check_eq("t6_rel_fin", get_fin(0), 0);
        check_eq("t6_rel_count", get_cnt(0), 0);
        q_a.delete();
        q_b.delete();
        rr_a = 0;
        send(0, 0, 3, 1'b1);
        check_eq("t6_no_pop", get_cnt(0), 1);
        tick();
        check_eq("t6_no_pop_hold", get_cnt(0), 1);
        set_rfin(0, 1'b0);
        tick();
        pop_check(0);
        check_eq("t6_final", get_cnt(0), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
